// File: rtl/jtag_pkg.sv
// Shared JTAG instruction codes and DR select type for the data-register bank.
// Pure declarations; no timing of its own.
package jtag_pkg;

    localparam int IR_WIDTH = 4;

    typedef logic [IR_WIDTH-1:0] ir_t;

    localparam ir_t IR_EXTEST   = 4'h0;
    localparam ir_t IR_IDCODE   = 4'h1;
    localparam ir_t IR_SAMPLE   = 4'h2;
    localparam ir_t IR_INTEST   = 4'h3;
    localparam ir_t IR_USERCODE = 4'h4;
    localparam ir_t IR_RUNBIST  = 4'h5;
    localparam ir_t IR_BYPASS   = 4'hF;

    typedef enum logic [2:0] {
        DR_BYP,
        DR_ID,
        DR_BSR,
        DR_UC,
        DR_BIST
    } dr_sel_t;

    // Undefined codes fall back to bypass so the chain length stays predictable.
    function automatic dr_sel_t decode_ir(input ir_t ir);
        dr_sel_t sel;
        case (ir)
            IR_EXTEST, IR_SAMPLE, IR_INTEST: sel = DR_BSR;
            IR_IDCODE:                       sel = DR_ID;
            IR_USERCODE:                     sel = DR_UC;
            IR_RUNBIST:                      sel = DR_BIST;
            default:                         sel = DR_BYP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_dr_bank_dr_shift.sv
// One JTAG data shift register: capture beats shift, holds when not enabled.
// Result visible after the posedge TCK carrying the strobe; no backpressure.
module dr_shift #(
    parameter int W = 8
) (
    input  logic         TCK,
    input  logic         TRST,
    input  logic         en,
    input  logic         cap,
    input  logic         shift,
    input  logic [W-1:0] cap_val,
    input  logic         TDI,
    output logic [W-1:0] sr
);

    logic [W-1:0] sr_d, sr_q, shifted;

    generate
        if (W == 1) begin : g_one
            assign shifted = TDI;
        end else begin : g_wide
            assign shifted = {TDI, sr_q[W-1:1]};
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            if (cap) begin
                sr_d = cap_val;
            end else if (shift) begin
                sr_d = shifted;
            end
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG DR bank: bypass/IDCODE/BSR/USERCODE/BIST shift chains, update latches, pin/core muxes.
// Latency: W posedges TDI->TDO plus a negedge retime; no backpressure (TAP-driven strobes).
module jtag_dr_bank
    import jtag_pkg::*;
#(
    parameter int                   N_PINS     = 8,
    parameter int                   ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0]  IDCODE     = 8'hA1,
    parameter int                   UC_WIDTH   = 8,
    parameter logic [UC_WIDTH-1:0]  UC_RESET   = 8'h01,
    parameter int                   BIST_WIDTH = 8
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TDI,
    input  logic [IR_WIDTH-1:0]   IR,
    input  logic                  CAPTUREDR,
    input  logic                  SHIFTDR,
    input  logic                  UPDATEDR,
    input  logic [N_PINS-1:0]     PIN_IN,
    input  logic [N_PINS-1:0]     CORE_OUT,
    input  logic [BIST_WIDTH-1:0] BIST_LOG,
    output logic [N_PINS-1:0]     PIN_OUT,
    output logic [N_PINS-1:0]     CORE_IN,
    output logic [UC_WIDTH-1:0]   UR_OUT,
    output logic                  TDO,
    output logic                  TDO_EN
);

    dr_sel_t dr_sel;
    assign dr_sel = decode_ir(IR);

    logic [0:0]            byp_sr;
    logic [ID_WIDTH-1:0]   id_sr;
    logic [N_PINS-1:0]     bsr_sr, bsr_cap;
    logic [UC_WIDTH-1:0]   uc_sr;
    logic [BIST_WIDTH-1:0] bist_sr;

    assign bsr_cap = (IR == IR_INTEST) ? CORE_OUT : PIN_IN;

    dr_shift #(.W(1)) u_byp (
        .TCK(TCK), .TRST(TRST), .en(dr_sel == DR_BYP), .cap(CAPTUREDR), .shift(SHIFTDR),
        .cap_val(1'b0), .TDI(TDI), .sr(byp_sr));

    dr_shift #(.W(ID_WIDTH)) u_id (
        .TCK(TCK), .TRST(TRST), .en(dr_sel == DR_ID), .cap(CAPTUREDR), .shift(SHIFTDR),
        .cap_val(IDCODE), .TDI(TDI), .sr(id_sr));

    dr_shift #(.W(N_PINS)) u_bsr (
        .TCK(TCK), .TRST(TRST), .en(dr_sel == DR_BSR), .cap(CAPTUREDR), .shift(SHIFTDR),
        .cap_val(bsr_cap), .TDI(TDI), .sr(bsr_sr));

    dr_shift #(.W(UC_WIDTH)) u_uc (
        .TCK(TCK), .TRST(TRST), .en(dr_sel == DR_UC), .cap(CAPTUREDR), .shift(SHIFTDR),
        .cap_val(UR_OUT), .TDI(TDI), .sr(uc_sr));

    dr_shift #(.W(BIST_WIDTH)) u_bist (
        .TCK(TCK), .TRST(TRST), .en(dr_sel == DR_BIST), .cap(CAPTUREDR), .shift(SHIFTDR),
        .cap_val(BIST_LOG), .TDI(TDI), .sr(bist_sr));

    // Update only when neither capture nor shift is asserted alongside it.
    logic                upd_go;
    logic [N_PINS-1:0]   bsr_upd_d, bsr_upd_q;
    logic [UC_WIDTH-1:0] ur_d, ur_q;

    assign upd_go = UPDATEDR && !CAPTUREDR && !SHIFTDR;

    always_comb begin
        bsr_upd_d = bsr_upd_q;
        ur_d      = ur_q;
        if (upd_go) begin
            if (dr_sel == DR_BSR) bsr_upd_d = bsr_sr;
            if (dr_sel == DR_UC)  ur_d      = uc_sr;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bsr_upd_q <= '0;
            ur_q      <= UC_RESET;
        end else begin
            bsr_upd_q <= bsr_upd_d;
            ur_q      <= ur_d;
        end
    end

    assign UR_OUT  = ur_q;
    assign PIN_OUT = (IR == IR_EXTEST) ? bsr_upd_q : CORE_OUT;
    assign CORE_IN = (IR == IR_INTEST) ? bsr_upd_q : PIN_IN;

    logic tdo_d, tdo_q, tdo_en_d, tdo_en_q;

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = SHIFTDR;
        case (dr_sel)
            DR_BYP:  tdo_d = byp_sr[0];
            DR_ID:   tdo_d = id_sr[0];
            DR_BSR:  tdo_d = bsr_sr[0];
            DR_UC:   tdo_d = uc_sr[0];
            DR_BIST: tdo_d = bist_sr[0];
            default: tdo_d = 1'b0;
        endcase
    end

    // Negedge retime so TDO is stable across the next capturing posedge.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO    = tdo_q;
    assign TDO_EN = tdo_en_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Self-checking bench for jtag_dr_bank: scoreboarded TDO stream plus parallel-output checks.
module tb_jtag_dr_bank;
    import jtag_pkg::*;

    logic       TCK = 1'b0;
    logic       TRST, TDI, CAPTUREDR, SHIFTDR, UPDATEDR;
    logic [3:0] IR;
    logic [7:0] PIN_IN, CORE_OUT, BIST_LOG;
    wire  [7:0] PIN_OUT, CORE_IN, UR_OUT;
    wire        TDO, TDO_EN;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic exp_q[$];

    jtag_dr_bank dut (
        .TCK(TCK), .TRST(TRST), .TDI(TDI), .IR(IR),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
        .PIN_IN(PIN_IN), .CORE_OUT(CORE_OUT), .BIST_LOG(BIST_LOG),
        .PIN_OUT(PIN_OUT), .CORE_IN(CORE_IN), .UR_OUT(UR_OUT),
        .TDO(TDO), .TDO_EN(TDO_EN));

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One TCK period; returns just after the negedge so TDO has settled.
    task automatic cyc();
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic tdo_cycle(input string tag, input logic en_exp);
        cyc();
        if (exp_q.size() > 0) check(tag, 32'(TDO), 32'(exp_q.pop_front()));
        else                  check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
        check({tag, "_en"}, 32'(TDO_EN), 32'(en_exp));
    endtask

    // Capture, n shift bits from din (LSB first), optional update; model tracks a w-bit DR.
    task automatic scan(input string tag, input int w, input logic [7:0] capv,
                        input logic [7:0] din, input int n, input bit upd);
        logic [7:0] m;
        CAPTUREDR = 1'b1;
        m = capv;
        exp_q.push_back(m[0]);
        tdo_cycle({tag, "_cap"}, 1'b0);
        CAPTUREDR = 1'b0;
        for (int i = 0; i < n; i++) begin
            SHIFTDR = 1'b1;
            TDI     = din[i];
            m       = m >> 1;
            m[w-1]  = din[i];
            exp_q.push_back(m[0]);
            tdo_cycle($sformatf("%s_sh%0d", tag, i), 1'b1);
        end
        SHIFTDR = 1'b0;
        TDI     = 1'b0;
        if (upd) begin
            UPDATEDR = 1'b1;
            cyc();
            UPDATEDR = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        TRST = 1'b1; TDI = 1'b0; IR = IR_EXTEST;
        CAPTUREDR = 1'b0; SHIFTDR = 1'b0; UPDATEDR = 1'b0;
        PIN_IN = 8'h99; CORE_OUT = 8'h66; BIST_LOG = 8'h5C;
        repeat (2) cyc();
        check("rst_tdo",     32'(TDO),     32'd0);
        check("rst_tdo_en",  32'(TDO_EN),  32'd0);
        check("rst_ur",      32'(UR_OUT),  32'h01);
        check("rst_pin_out", 32'(PIN_OUT), 32'h00);
        check("rst_core_in", 32'(CORE_IN), 32'h99);
        TRST = 1'b0;

        IR = IR_IDCODE; #1;
        check("id_pin_out_follow", 32'(PIN_OUT), 32'h66);
        scan("id", 8, 8'hA1, 8'h00, 8, 1'b0);

        IR = 4'h7;
        scan("undef_byp", 1, 8'h00, 8'b0000_0101, 3, 1'b0);

        IR = IR_SAMPLE;
        scan("sample", 8, 8'h99, 8'h5A, 8, 1'b1);
        IR = IR_EXTEST; #1;
        check("extest_pin_out", 32'(PIN_OUT), 32'h5A);
        check("extest_core_in", 32'(CORE_IN), 32'h99);
        PIN_IN = 8'h3C;
        scan("extest_cap", 8, 8'h3C, 8'h00, 8, 1'b0);
        check("extest_pin_hold", 32'(PIN_OUT), 32'h5A);

        IR = IR_USERCODE;
        scan("uc", 8, 8'h01, 8'hC3, 8, 1'b1);
        check("uc_ur_out",  32'(UR_OUT),  32'hC3);
        check("uc_pin_out", 32'(PIN_OUT), 32'h66);

        // uc_sr becomes 0x61 so a wrongly honoured update would be visible.
        SHIFTDR = 1'b1; TDI = 1'b0;
        exp_q.push_back(1'b1);
        tdo_cycle("prio_pre", 1'b1);
        SHIFTDR = 1'b0; CAPTUREDR = 1'b1; UPDATEDR = 1'b1;
        exp_q.push_back(1'b1);
        tdo_cycle("prio_capupd", 1'b0);
        CAPTUREDR = 1'b0; UPDATEDR = 1'b0;
        check("prio_ur_hold", 32'(UR_OUT), 32'hC3);

        IR = IR_INTEST; CORE_OUT = 8'hF0;
        scan("intest", 8, 8'hF0, 8'h0F, 8, 1'b1);
        check("intest_core_in", 32'(CORE_IN), 32'h0F);
        check("intest_pin_out", 32'(PIN_OUT), 32'hF0);

        IR = IR_USERCODE;
        scan("trst", 8, 8'hC3, 8'hFF, 4, 1'b0);
        #2 TRST = 1'b1;
        #1 check("trst_tdo_async", 32'(TDO), 32'd0);
        UPDATEDR = 1'b1;
        cyc();
        UPDATEDR = 1'b0;
        check("trst_ur",     32'(UR_OUT), 32'h01);
        check("trst_tdo",    32'(TDO),    32'd0);
        check("trst_tdo_en", 32'(TDO_EN), 32'd0);
        IR = IR_EXTEST; #1;
        check("trst_bsr_upd", 32'(PIN_OUT), 32'h00);
        TRST = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
